// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the parametrised synchronous FIFO family.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO, any depth >= 2; registered (1-cycle) or fall-through read.
// Writes dropped when full, reads ignored when empty; both raise sticky error flags.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      w_en,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      r_en,
  input  logic                      flush,
  input  logic                      err_clr,
  output logic [WIDTH-1:0]          data_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  always_comb begin
    wr_acc   = w_en && !full && !flush;
    rd_acc   = r_en && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_next(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_next(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Clear wins over a coincident new error.
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (!flush) begin
      if (w_en && full)  ovf_d = 1'b1;
      if (r_en && empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc && rst_n),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [WIDTH-1:0] dout_q, dout_d;

    assign dout_d = rd_acc ? mem_rdata : dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end else begin : g_fwft
    // Head word is don't-care while empty; forcing zero keeps reset value clean.
    assign data_out = empty ? '0 : mem_rdata;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed checks of param_sync_fifo: 8-deep standard, 6-deep scoreboard, 4-deep fall-through.
module tb_param_sync_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instance A: DEPTH 8, AF 6, AE 2, standard read
  logic       a_wen = 0, a_ren = 0, a_flush = 0, a_eclr = 0;
  logic [7:0] a_din = 0, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [3:0] a_cnt;

  param_sync_fifo #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .w_en(a_wen), .data_in(a_din), .r_en(a_ren),
    .flush(a_flush), .err_clr(a_eclr), .data_out(a_dout), .full(a_full),
    .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
    .overflow(a_ovf), .underflow(a_unf)
  );

  // Instance B: DEPTH 6 (non power of two), standard read
  logic       b_wen = 0, b_ren = 0;
  logic [7:0] b_din = 0, b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_cnt;

  param_sync_fifo #(.WIDTH(8), .DEPTH(6), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .w_en(b_wen), .data_in(b_din), .r_en(b_ren),
    .flush(1'b0), .err_clr(1'b0), .data_out(b_dout), .full(b_full),
    .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
    .overflow(b_ovf), .underflow(b_unf)
  );

  // Instance C: DEPTH 4, first-word-fall-through
  logic       c_wen = 0, c_ren = 0;
  logic [7:0] c_din = 0, c_dout;
  logic       c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [2:0] c_cnt;

  param_sync_fifo #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .w_en(c_wen), .data_in(c_din), .r_en(c_ren),
    .flush(1'b0), .err_clr(1'b0), .data_out(c_dout), .full(c_full),
    .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae), .count(c_cnt),
    .overflow(c_ovf), .underflow(c_unf)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] head;
    logic       exp_w, exp_r, m_ovf, m_unf;
    int         guard;

    // Reset state
    #12;
    check("rst_count", 32'(a_cnt), 0);
    check("rst_empty", 32'(a_empty), 1);
    check("rst_full", 32'(a_full), 0);
    check("rst_ae", 32'(a_ae), 1);
    check("rst_af", 32'(a_af), 0);
    check("rst_dout", 32'(a_dout), 0);
    check("rst_ovf", 32'(a_ovf), 0);
    check("rst_unf", 32'(a_unf), 0);
    check("rst_c_dout", 32'(c_dout), 0);
    rst_n = 1'b1;
    step();

    // Fill 0x01..0x08, watching the threshold flags
    for (int i = 1; i <= 8; i++) begin
      a_wen = 1; a_din = 8'(i);
      step();
      check($sformatf("fill_cnt%0d", i), 32'(a_cnt), 32'(i));
      check($sformatf("fill_ae%0d", i), 32'(a_ae), (i <= 2) ? 1 : 0);
      check($sformatf("fill_af%0d", i), 32'(a_af), (i >= 6) ? 1 : 0);
      check($sformatf("fill_full%0d", i), 32'(a_full), (i == 8) ? 1 : 0);
    end

    // Extra write while full
    a_din = 8'h99;
    step();
    check("ovf_set", 32'(a_ovf), 1);
    check("ovf_cnt", 32'(a_cnt), 8);

    // Simultaneous write+read on full: only the read is taken
    a_din = 8'hAA; a_ren = 1;
    step();
    check("wr_rd_full_cnt", 32'(a_cnt), 7);
    check("wr_rd_full_full", 32'(a_full), 0);
    check("wr_rd_full_dout", 32'(a_dout), 8'h01);
    a_wen = 0;

    for (int i = 2; i <= 8; i++) begin
      step();
      check($sformatf("drain_%0d", i), 32'(a_dout), 32'(i));
    end
    check("drain_cnt", 32'(a_cnt), 0);
    check("drain_empty", 32'(a_empty), 1);

    // Read while empty
    step();
    check("unf_set", 32'(a_unf), 1);
    check("unf_dout_hold", 32'(a_dout), 8'h08);
    check("unf_cnt", 32'(a_cnt), 0);
    a_eclr = 1;
    step();
    check("unf_clr", 32'(a_unf), 0);
    check("ovf_clr", 32'(a_ovf), 0);
    a_eclr = 0; a_ren = 0;

    // Flush with a concurrent write
    a_wen = 1;
    foreach (q[i]) q.delete(i);
    for (int i = 0; i < 3; i++) begin
      a_din = 8'(8'h11 * (i + 1));
      step();
    end
    check("pre_flush_cnt", 32'(a_cnt), 3);
    a_flush = 1; a_din = 8'h44;
    step();
    a_flush = 0; a_wen = 0;
    check("flush_cnt", 32'(a_cnt), 0);
    check("flush_empty", 32'(a_empty), 1);
    check("flush_dout", 32'(a_dout), 8'h08);
    check("flush_ovf", 32'(a_ovf), 0);
    step();
    check("flush_no_write", 32'(a_cnt), 0);

    // DEPTH 6: interleaved traffic against a queue model
    m_ovf = 0; m_unf = 0;
    for (int k = 0; k < 40; k++) begin
      b_wen = ($urandom_range(0, 3) != 0);
      b_ren = ($urandom_range(0, 1) == 1);
      b_din = 8'($urandom_range(0, 255));
      exp_w = b_wen && (q.size() < 6);
      exp_r = b_ren && (q.size() > 0);
      if (b_wen && q.size() == 6) m_ovf = 1;
      if (b_ren && q.size() == 0) m_unf = 1;
      head = 8'h00;
      if (exp_r) head = q.pop_front();
      if (exp_w) q.push_back(b_din);
      step();
      if (exp_r) check($sformatf("b_data%0d", k), 32'(b_dout), 32'(head));
      check($sformatf("b_cnt%0d", k), 32'(b_cnt), 32'(q.size()));
      check($sformatf("b_full%0d", k), 32'(b_full), (q.size() == 6) ? 1 : 0);
      check($sformatf("b_empty%0d", k), 32'(b_empty), (q.size() == 0) ? 1 : 0);
      check($sformatf("b_ovf%0d", k), 32'(b_ovf), 32'(m_ovf));
      check($sformatf("b_unf%0d", k), 32'(b_unf), 32'(m_unf));
    end
    b_wen = 0; b_ren = 1;
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      head = q.pop_front();
      step();
      check("b_drain", 32'(b_dout), 32'(head));
      guard++;
    end
    b_ren = 0;
    check("b_drain_empty", 32'(b_empty), 1);

    // Fall-through mode
    check("c_empty0", 32'(c_empty), 1);
    c_wen = 1; c_din = 8'h5A;
    step();
    c_wen = 0;
    check("c_fwft_data", 32'(c_dout), 8'h5A);
    check("c_fwft_empty", 32'(c_empty), 0);
    step();
    check("c_fwft_hold", 32'(c_dout), 8'h5A);
    c_ren = 1;
    step();
    c_ren = 0;
    check("c_pop_empty", 32'(c_empty), 1);
    c_wen = 1; c_din = 8'h10;
    step();
    c_din = 8'h20;
    step();
    c_wen = 0;
    check("c_head1", 32'(c_dout), 8'h10);
    c_ren = 1;
    step();
    c_ren = 0;
    check("c_head2", 32'(c_dout), 8'h20);
    check("c_cnt", 32'(c_cnt), 1);

    // Asynchronous reset in the middle of a burst
    a_wen = 1; a_din = 8'h61;
    step();
    a_din = 8'h62;
    step();
    a_ren = 1; a_din = 8'h63;
    step();
    check("burst_dout", 32'(a_dout), 8'h61);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", 32'(a_cnt), 0);
    check("arst_dout", 32'(a_dout), 0);
    check("arst_empty", 32'(a_empty), 1);
    check("arst_c_dout", 32'(c_dout), 0);
    a_wen = 0; a_ren = 0;
    #10;
    rst_n = 1'b1;
    step();
    check("post_rst_cnt", 32'(a_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
